// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store. Data
// requests have fixed priority, and a streak counter bounds how long fetch can starve.
module mem_arbiter #(
    parameter int unsigned Width        = 32,
    parameter int unsigned Latency      = 1,
    parameter int unsigned MaxDataBurst = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [Width-1:0] if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [Width-1:0] if_rdata,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [3:0]       dm_wsel,
    input  logic [Width-1:0] dm_addr,
    input  logic [Width-1:0] dm_wdata,
    output logic             dm_gnt,
    output logic             dm_rvalid,
    output logic [Width-1:0] dm_rdata,
    output logic             mem_re,
    output logic             mem_we,
    output logic [Width-1:0] mem_addr,
    output logic [3:0]       mem_w_sel,
    output logic [Width-1:0] mem_w_data,
    input  logic [Width-1:0] mem_r_data,
    output logic             stallreq_if,
    output logic             stallreq_mem
);

    localparam int unsigned CntW    = 3;
    localparam int unsigned StreakW = 4;

    localparam logic [CntW-1:0]    LatInit   = CntW'(Latency - 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MaxDataBurst);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [CntW-1:0]     lat_cnt_q, lat_cnt_d;
    logic [StreakW-1:0]  streak_q, streak_d;

    logic rd_done;
    logic window;
    logic gnt_dm;
    logic gnt_if;
    logic gnt_read;

    // The issue window reopens on the rvalid cycle so reads can run back to back.
    assign rd_done  = (state_q == S_BUSY) && (lat_cnt_q == '0);
    assign window   = (state_q == S_IDLE) || rd_done;
    assign gnt_dm   = rst && window && dm_req && !(if_req && (streak_q == StreakMax));
    assign gnt_if   = rst && window && !gnt_dm && if_req;
    assign gnt_read = (gnt_dm && !dm_we) || gnt_if;

    assign if_gnt = gnt_if;
    assign dm_gnt = gnt_dm;

    // RAM port drive: winner's attributes, all-zero when nobody is granted.
    always_comb begin
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_w_sel  = '0;
        mem_w_data = '0;
        if (gnt_dm) begin
            mem_re     = !dm_we;
            mem_we     = dm_we;
            mem_addr   = dm_addr;
            mem_w_sel  = dm_wsel;
            mem_w_data = dm_wdata;
        end else if (gnt_if) begin
            mem_re   = 1'b1;
            mem_addr = if_addr;
        end
    end

    assign if_rvalid = rd_done && (owner_q == OWN_IF);
    assign dm_rvalid = rd_done && (owner_q == OWN_DM);
    assign if_rdata  = if_rvalid ? mem_r_data : '0;
    assign dm_rdata  = dm_rvalid ? mem_r_data : '0;

    assign stallreq_if  = (if_req && !gnt_if) ||
                          ((state_q == S_BUSY) && (owner_q == OWN_IF) && !if_rvalid);
    assign stallreq_mem = (dm_req && !gnt_dm) ||
                          ((state_q == S_BUSY) && (owner_q == OWN_DM) && !dm_rvalid);

    // Next-state: latency countdown, read ownership and fetch-starvation streak.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        streak_d  = streak_q;

        if ((state_q == S_BUSY) && (lat_cnt_q != '0)) begin
            lat_cnt_d = lat_cnt_q - CntW'(1);
        end else if (gnt_read) begin
            state_d   = S_BUSY;
            owner_d   = gnt_dm ? OWN_DM : OWN_IF;
            lat_cnt_d = LatInit;
        end else begin
            state_d   = S_IDLE;
            lat_cnt_d = '0;
        end

        if (!if_req || gnt_if) begin
            streak_d = '0;
        end else if (gnt_dm && (streak_q != StreakMax)) begin
            streak_d = streak_q + StreakW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_IF;
            lat_cnt_q <= '0;
            streak_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            streak_q  <= streak_d;
        end
    end

endmodule
